avalon_distance_poller: RTL and testbench
=========================================

// Module: avalon_distance_poller
// PURPOSE
//  Avalon-style read initiator for the ultrasonic distance peripheral. Periodically polls
//  STATUS; when a reading is valid, fetches DATA_OUT, CAR_COUNT and CAR_BIT in a fixed burst,
//  then presents them as one coherent snapshot. Sits between the peripheral's io_select/address/
//  read_data port and local consumers (hex display driver, logger).
// PARAMETERS
//  BASE_ADDR      16'h0900  peripheral base; DATA_OUT=+0, STATUS=+4, CAR_COUNT=+8, CAR_BIT=+C
//  POLL_INTERVAL  50000     clk cycles between poll launches (>=8)
//  READ_LATENCY   1         cycles from io_select cycle to read_data valid (1..3)
//  MAX_MISSES     8         consecutive not-ready STATUS reads before stale asserts (1..255)
// PORTS
//  clk           in   1   clock
//  reset_l       in   1   asynchronous, active-low reset
//  enable        in   1   level; 1 = polling allowed
//  io_select     out  1   read strobe to peripheral, exactly one cycle per read
//  address       out  16  read address, valid while io_select=1
//  read_data     in   16  peripheral read data (may be Z outside valid cycle)
//  distance      out  16  last committed DATA_OUT value
//  car_count     out  6   last committed CAR_COUNT[5:0]
//  car_present   out  1   last committed CAR_BIT[0]
//  sample_valid  out  1   one-cycle pulse when snapshot committed
//  stale         out  1   1 after MAX_MISSES consecutive not-ready polls
//  busy          out  1   1 in any state other than IDLE
// BEHAVIOUR
//  Reset: io_select=0, address=16'h0000, distance=0, car_count=0, car_present=0,
//   sample_valid=0, stale=0, busy=0, FSM=IDLE, interval counter=0, miss counter=0.
//  Interval counter: enable=0 -> held at 0. enable=1 -> counts 0..POLL_INTERVAL-1 and wraps;
//   launch when count==POLL_INTERVAL-1 and FSM==IDLE; first launch POLL_INTERVAL cycles after
//   enable rises. Launch while busy is dropped (no queueing).
//  Read cycle: cycle N io_select=1, address=target; cycles N+1..N+READ_LATENCY io_select=0,
//   address=16'h0000; read_data sampled on the edge ending cycle N+READ_LATENCY. Never sample
//   read_data at any other cycle (Z tolerated). One read = 1+READ_LATENCY cycles.
//  FSM: IDLE -> RD_STATUS -> WT_STATUS -> (status[0]=1) RD_DIST -> WT_DIST -> RD_CNT -> WT_CNT
//   -> RD_CAR -> WT_CAR -> COMMIT -> IDLE; (status[0]=0) WT_STATUS -> IDLE.
//  Shadow regs capture DIST/CNT/CAR; outputs update only in COMMIT (atomic), sample_valid=1
//   that cycle only. Full valid poll = 4*(1+READ_LATENCY)+1 cycles from launch.
//  Misses: status[0]=0 -> miss counter +1 (saturate 255); stale=1 when counter>=MAX_MISSES.
//   COMMIT clears miss counter and stale same cycle. Outputs unchanged on miss.
//  car_count takes read_data[5:0]; read_data[15:6] ignored. car_present = read_data[0].
//  enable falls mid-burst: burst completes (incl. COMMIT), then IDLE; no new launch.
//  Async reset mid-burst: immediate return to reset values; shadow data discarded.
// TESTING
//  T1 reset: assert reset_l=0 mid-burst -> all outputs at reset values same cycle, io_select=0.
//  T2 valid poll, POLL_INTERVAL=8, LAT=1: STATUS=1, DATA=16'h0123, CNT=16'h0005, CAR=1 ->
//     io_select at 0x0904,0x0900,0x0908,0x090C spaced 2 cycles; sample_valid 9 cycles after
//     launch; distance=0x0123, car_count=5, car_present=1.
//  T3 not ready: STATUS=0 for 8 polls, MAX_MISSES=8 -> no sample_valid, stale rises after 8th;
//     then one valid poll -> stale=0 on commit cycle.
//  T4 atomicity: change DATA stub mid-burst -> outputs hold old values until COMMIT only.
//  T5 LAT=3: read_data driven Z except capture cycle -> correct capture, no X on outputs.
//  T6 enable drop during WT_CNT -> burst commits, then io_select stays 0 for 3*POLL_INTERVAL.

Source files
------------

// File: rtl/avalon_distance_poller.sv
// Avalon-style read initiator that polls the ultrasonic distance peripheral and
// publishes DATA_OUT / CAR_COUNT / CAR_BIT as one coherent snapshot.
module avalon_distance_poller #(
  parameter logic [15:0] BASE_ADDR     = 16'h0900,
  parameter int          POLL_INTERVAL = 50000,
  parameter int          READ_LATENCY  = 1,
  parameter int          MAX_MISSES    = 8
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        enable,
  output logic        io_select,
  output logic [15:0] address,
  input  logic [15:0] read_data,
  output logic [15:0] distance,
  output logic [5:0]  car_count,
  output logic        car_present,
  output logic        sample_valid,
  output logic        stale,
  output logic        busy
);

  localparam int             CW         = $clog2(POLL_INTERVAL);
  localparam logic [CW-1:0]  INT_LAST   = CW'(POLL_INTERVAL - 1);
  localparam logic [1:0]     LAT_LAST   = 2'(READ_LATENCY - 1);
  localparam logic [7:0]     MISS_LIMIT = 8'(MAX_MISSES);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] RD_STATUS = 4'd1;
  localparam logic [3:0] WT_STATUS = 4'd2;
  localparam logic [3:0] RD_DIST   = 4'd3;
  localparam logic [3:0] WT_DIST   = 4'd4;
  localparam logic [3:0] RD_CNT    = 4'd5;
  localparam logic [3:0] WT_CNT    = 4'd6;
  localparam logic [3:0] RD_CAR    = 4'd7;
  localparam logic [3:0] WT_CAR    = 4'd8;
  localparam logic [3:0] COMMIT    = 4'd9;

  // Bus handshake: io_select is high for exactly one cycle per read with address
  // valid alongside it; read_data is trusted only on the edge ending the last wait cycle.
  logic [3:0]    state;
  logic [3:0]    state_nxt;
  logic [CW-1:0] int_cnt;
  logic [1:0]    lat_cnt;
  logic [7:0]    miss_cnt;
  logic [7:0]    miss_inc;
  logic [15:0]   dist_shadow;
  logic [5:0]    cnt_shadow;
  logic          launch;
  logic          wait_state;
  logic          lat_done;
  logic          capture;

  assign launch     = enable && (int_cnt == INT_LAST) && (state == IDLE);
  assign wait_state = state inside {WT_STATUS, WT_DIST, WT_CNT, WT_CAR};
  assign lat_done   = (lat_cnt == LAT_LAST);
  assign capture    = wait_state && lat_done;
  assign miss_inc   = (miss_cnt == 8'hFF) ? miss_cnt : miss_cnt + 8'd1;

  assign busy      = (state != IDLE);
  assign io_select = state inside {RD_STATUS, RD_DIST, RD_CNT, RD_CAR};

  always_comb begin
    address = 16'h0000;
    case (state)
      RD_STATUS: address = BASE_ADDR + 16'h0004;
      RD_DIST:   address = BASE_ADDR;
      RD_CNT:    address = BASE_ADDR + 16'h0008;
      RD_CAR:    address = BASE_ADDR + 16'h000C;
      default:   address = 16'h0000;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (launch) state_nxt = RD_STATUS;
      RD_STATUS: state_nxt = WT_STATUS;
      WT_STATUS: if (lat_done) state_nxt = read_data[0] ? RD_DIST : IDLE;
      RD_DIST:   state_nxt = WT_DIST;
      WT_DIST:   if (lat_done) state_nxt = RD_CNT;
      RD_CNT:    state_nxt = WT_CNT;
      WT_CNT:    if (lat_done) state_nxt = RD_CAR;
      RD_CAR:    state_nxt = WT_CAR;
      WT_CAR:    if (lat_done) state_nxt = COMMIT;
      COMMIT:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state   <= IDLE;
      int_cnt <= '0;
      lat_cnt <= 2'd0;
    end else begin
      state <= state_nxt;
      if (!enable || int_cnt == INT_LAST) int_cnt <= '0;
      else                                int_cnt <= int_cnt + 1'b1;
      if (wait_state && !lat_done) lat_cnt <= lat_cnt + 2'd1;
      else                         lat_cnt <= 2'd0;
    end
  end

  // The committed registers load on the edge entering COMMIT, so the snapshot and
  // sample_valid are visible together during the COMMIT cycle; CAR_BIT goes straight in.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      dist_shadow  <= 16'h0000;
      cnt_shadow   <= 6'd0;
      distance     <= 16'h0000;
      car_count    <= 6'd0;
      car_present  <= 1'b0;
      sample_valid <= 1'b0;
      miss_cnt     <= 8'd0;
      stale        <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (capture) begin
        case (state)
          WT_STATUS: begin
            if (!read_data[0]) begin
              miss_cnt <= miss_inc;
              stale    <= (miss_inc >= MISS_LIMIT);
            end
          end
          WT_DIST: dist_shadow <= read_data;
          WT_CNT:  cnt_shadow  <= read_data[5:0];
          WT_CAR: begin
            distance     <= dist_shadow;
            car_count    <= cnt_shadow;
            car_present  <= read_data[0];
            sample_valid <= 1'b1;
            miss_cnt     <= 8'd0;
            stale        <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_avalon_distance_poller.sv
// Directed bench: a LAT=1 poller and a LAT=3 poller, each behind a register stub
// that drives read_data only in the cycle the read completes.
module tb_avalon_distance_poller;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        enable1 = 1'b0, enable3 = 1'b0;
  logic        io_sel1, io_sel3;
  logic [15:0] addr1, addr3;
  logic [15:0] rd1, rd3;
  logic [15:0] distance1, distance3;
  logic [5:0]  car_count1, car_count3;
  logic        car_present1, car_present3;
  logic        sample_valid1, sample_valid3;
  logic        stale1, stale3;
  logic        busy1, busy3;

  logic [15:0] stat1 = 16'h0, dist1 = 16'h0, cnt1 = 16'h0, car1 = 16'h0;
  logic [15:0] stat3 = 16'h0, dist3 = 16'h0, cnt3 = 16'h0, car3 = 16'h0;

  always #5 clk = ~clk;

  avalon_distance_poller #(.BASE_ADDR(16'h0900), .POLL_INTERVAL(8), .READ_LATENCY(1),
                           .MAX_MISSES(8)) dut1 (
    .clk(clk), .reset_l(reset_l), .enable(enable1), .io_select(io_sel1), .address(addr1),
    .read_data(rd1), .distance(distance1), .car_count(car_count1),
    .car_present(car_present1), .sample_valid(sample_valid1), .stale(stale1), .busy(busy1));

  avalon_distance_poller #(.BASE_ADDR(16'h0900), .POLL_INTERVAL(8), .READ_LATENCY(3),
                           .MAX_MISSES(8)) dut3 (
    .clk(clk), .reset_l(reset_l), .enable(enable3), .io_select(io_sel3), .address(addr3),
    .read_data(rd3), .distance(distance3), .car_count(car_count3),
    .car_present(car_present3), .sample_valid(sample_valid3), .stale(stale3), .busy(busy3));

  function automatic logic [15:0] lookup(input logic [15:0] a, input logic [15:0] s,
                                         input logic [15:0] d, input logic [15:0] c,
                                         input logic [15:0] b);
    case (a)
      16'h0900: lookup = d;
      16'h0904: lookup = s;
      16'h0908: lookup = c;
      16'h090C: lookup = b;
      default:  lookup = 16'hDEAD;
    endcase
  endfunction

  // Peripheral stubs: data appears only READ_LATENCY cycles after the strobe, Z otherwise.
  logic        p1_v = 1'b0;
  logic [15:0] p1_a = 16'h0;
  logic [2:0]  p3_v = 3'b000;
  logic [15:0] p3_a0 = 16'h0, p3_a1 = 16'h0, p3_a2 = 16'h0;

  always @(posedge clk) begin
    p1_v  <= io_sel1;
    p1_a  <= addr1;
    p3_v  <= {p3_v[1:0], io_sel3};
    p3_a0 <= addr3;
    p3_a1 <= p3_a0;
    p3_a2 <= p3_a1;
  end

  assign rd1 = p1_v    ? lookup(p1_a, stat1, dist1, cnt1, car1)  : 16'hzzzz;
  assign rd3 = p3_v[2] ? lookup(p3_a2, stat3, dist3, cnt3, car3) : 16'hzzzz;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sel1();
    int n;
    n = 0;
    while (io_sel1 !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("wait_sel1", {15'd0, io_sel1}, 16'd1);
  endtask

  task automatic wait_sel3();
    int n;
    n = 0;
    while (io_sel3 !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("wait_sel3", {15'd0, io_sel3}, 16'd1);
  endtask

  initial begin
    int hits;

    // Reset state
    tick(3);
    check("rst_sel", {15'd0, io_sel1}, 16'd0);
    check("rst_addr", addr1, 16'h0000);
    check("rst_busy", {15'd0, busy1}, 16'd0);
    check("rst_sv", {15'd0, sample_valid1}, 16'd0);
    check("rst_stale", {15'd0, stale1}, 16'd0);
    check("rst_dist", distance1, 16'h0000);
    reset_l = 1'b1;
    tick(2);

    // T2: first valid poll, launch 8 cycles after enable, reads spaced 2 cycles
    stat1 = 16'h0001; dist1 = 16'h0123; cnt1 = 16'h0005; car1 = 16'h0001;
    enable1 = 1'b1;
    tick(7);
    check("t2_pre_launch", {15'd0, io_sel1}, 16'd0);
    tick(1);
    check("t2_sel_status", {15'd0, io_sel1}, 16'd1);
    check("t2_addr_status", addr1, 16'h0904);
    check("t2_busy", {15'd0, busy1}, 16'd1);
    tick(1);
    check("t2_wait_sel", {15'd0, io_sel1}, 16'd0);
    check("t2_wait_addr", addr1, 16'h0000);
    tick(1);
    check("t2_addr_dist", addr1, 16'h0900);
    tick(2);
    check("t2_addr_cnt", addr1, 16'h0908);
    tick(2);
    check("t2_addr_car", addr1, 16'h090C);
    tick(1);
    check("t2_pre_commit_sv", {15'd0, sample_valid1}, 16'd0);
    check("t2_pre_commit_dist", distance1, 16'h0000);
    tick(1);
    check("t2_sv", {15'd0, sample_valid1}, 16'd1);
    check("t2_dist", distance1, 16'h0123);
    check("t2_cnt", {10'd0, car_count1}, 16'd5);
    check("t2_car", {15'd0, car_present1}, 16'd1);
    tick(1);
    check("t2_sv_pulse", {15'd0, sample_valid1}, 16'd0);
    check("t2_idle", {15'd0, busy1}, 16'd0);

    // T4: atomicity; DIST changes before and after its read, upper CNT bits ignored
    wait_sel1();
    dist1 = 16'h0456; cnt1 = 16'h0FC7; car1 = 16'hFFFE;
    tick(5);
    dist1 = 16'h0FFF;
    check("t4_hold_a", distance1, 16'h0123);
    tick(2);
    check("t4_hold_b", distance1, 16'h0123);
    check("t4_hold_cnt", {10'd0, car_count1}, 16'd5);
    tick(1);
    check("t4_sv", {15'd0, sample_valid1}, 16'd1);
    check("t4_dist", distance1, 16'h0456);
    check("t4_cnt", {10'd0, car_count1}, 16'd7);
    check("t4_car", {15'd0, car_present1}, 16'd0);

    // T3: eight not-ready polls raise stale; a valid poll clears it on commit
    stat1 = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      wait_sel1();
      check("t3_addr", addr1, 16'h0904);
      tick(1);
      check("t3_stale_before", {15'd0, stale1}, 16'd0);
      tick(1);
      check("t3_stale_after", {15'd0, stale1}, (i == 7) ? 16'd1 : 16'd0);
      check("t3_no_sv", {15'd0, sample_valid1}, 16'd0);
      check("t3_dist_kept", distance1, 16'h0456);
    end
    stat1 = 16'h0001; dist1 = 16'h0789; cnt1 = 16'h003F; car1 = 16'h0001;
    wait_sel1();
    tick(7);
    check("t3_stale_held", {15'd0, stale1}, 16'd1);
    tick(1);
    check("t3_stale_clr", {15'd0, stale1}, 16'd0);
    check("t3_sv", {15'd0, sample_valid1}, 16'd1);
    check("t3_dist", distance1, 16'h0789);
    check("t3_cnt", {10'd0, car_count1}, 16'd63);

    // T6: enable drops in WT_CNT; burst commits, then no further strobes
    dist1 = 16'h0ABC; cnt1 = 16'h0011; car1 = 16'h0000;
    wait_sel1();
    tick(5);
    enable1 = 1'b0;
    tick(3);
    check("t6_sv", {15'd0, sample_valid1}, 16'd1);
    check("t6_dist", distance1, 16'h0ABC);
    check("t6_cnt", {10'd0, car_count1}, 16'd17);
    hits = 0;
    for (int i = 0; i < 24; i++) begin
      tick(1);
      if (io_sel1 === 1'b1) hits++;
    end
    check("t6_no_strobe", 16'(hits), 16'd0);
    check("t6_idle", {15'd0, busy1}, 16'd0);

    // T5: READ_LATENCY=3 with read_data Z outside the capture cycle
    stat3 = 16'h0001; dist3 = 16'hBEEF; cnt3 = 16'h002A; car3 = 16'h0001;
    enable3 = 1'b1;
    wait_sel3();
    check("t5_addr_status", addr3, 16'h0904);
    tick(1);
    check("t5_wait_sel", {15'd0, io_sel3}, 16'd0);
    tick(3);
    check("t5_addr_dist", addr3, 16'h0900);
    tick(4);
    check("t5_addr_cnt", addr3, 16'h0908);
    tick(4);
    check("t5_addr_car", addr3, 16'h090C);
    tick(3);
    check("t5_pre_sv", {15'd0, sample_valid3}, 16'd0);
    check("t5_pre_dist", distance3, 16'h0000);
    tick(1);
    check("t5_sv", {15'd0, sample_valid3}, 16'd1);
    check("t5_dist", distance3, 16'hBEEF);
    check("t5_cnt", {10'd0, car_count3}, 16'd42);
    check("t5_car", {15'd0, car_present3}, 16'd1);
    check("t5_stale", {15'd0, stale3}, 16'd0);
    enable3 = 1'b0;
    tick(2);

    // T1: asynchronous reset in the middle of a burst
    enable1 = 1'b1;
    wait_sel1();
    tick(3);
    check("t1_busy_before", {15'd0, busy1}, 16'd1);
    reset_l = 1'b0;
    #1;
    check("t1_sel", {15'd0, io_sel1}, 16'd0);
    check("t1_addr", addr1, 16'h0000);
    check("t1_busy", {15'd0, busy1}, 16'd0);
    check("t1_dist", distance1, 16'h0000);
    check("t1_cnt", {10'd0, car_count1}, 16'd0);
    check("t1_car", {15'd0, car_present1}, 16'd0);
    check("t1_dist3", distance3, 16'h0000);
    tick(2);
    reset_l = 1'b1;
    enable1 = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
